// File: rtl/vram_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vram_seq_pkg
// Brief   : Shared constants, types and helpers for the VRAM address sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package vram_seq_pkg;

    localparam logic [3:0] CH_IDLE = 4'hF;

    typedef logic [2:0] ch_idx_t;

    // 052109 round: CPU on every odd slot, layer A twice, layer B and fix once.
    localparam logic [31:0] DEFAULT_SLOT_MAP = 32'h0302_0101;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module  : vram_tag_pipe
// Brief   : RD_LAT-deep read-tag shift register with one-hot read strobe decode.
// Rev     : 1.0  initial release
// ============================================================================
module vram_tag_pipe #(
    parameter int NCH    = 4,
    parameter int CW     = 2,
    parameter int RD_LAT = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_ce,
    input  logic           i_valid,
    input  logic [CW-1:0]  i_ch,
    output logic [NCH-1:0] o_rd_stb
);

    logic           r_vld [RD_LAT];
    logic [CW-1:0]  r_ch  [RD_LAT];
    logic [NCH-1:0] r_stb;
    logic [NCH-1:0] w_dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_ch[i]  <= '0;
            end
            r_stb <= '0;
        end else begin
            // Strobe is qualified by ce so it never lasts longer than one clk.
            r_stb <= i_ce ? w_dec : '0;
            if (i_ce) begin
                r_vld[0] <= i_valid;
                r_ch[0]  <= i_ch;
                for (int i = 1; i < RD_LAT; i++) begin
                    r_vld[i] <= r_vld[i-1];
                    r_ch[i]  <= r_ch[i-1];
                end
            end
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
        assign w_dec[gi] = r_vld[RD_LAT-1] && (r_ch[RD_LAT-1] == CW'(gi));
    end

    assign o_rd_stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/vram_addr_seq.sv
`default_nettype none
// ============================================================================
// Module  : vram_addr_seq
// Brief   : Slot-scheduled VRAM address sequencer with CPU handshake and read tags.
// Rev     : 1.0  initial release
// ============================================================================
module vram_addr_seq
    import vram_seq_pkg::*;
#(
    parameter int                 AW       = 13,
    parameter int                 NCH      = 4,
    parameter int                 SLOTS    = 8,
    parameter logic [SLOTS*4-1:0] SLOT_MAP = DEFAULT_SLOT_MAP,
    parameter int                 CPU_CH   = 0,
    parameter int                 RD_LAT   = 2,
    localparam int                CW       = clog2(NCH),
    localparam int                SW       = clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              sync,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH-1:0]    ch_en,
    input  logic              cpu_req,
    input  logic              cpu_we,
    output logic              cpu_ack,
    output logic [AW-1:0]     ra,
    output logic              ra_valid,
    output logic              ra_we,
    output logic [CW-1:0]     ra_ch,
    output logic [NCH-1:0]    rd_stb,
    output logic [SW-1:0]     slot
);

    localparam logic [3:0]    c_NCH4 = 4'(NCH);
    localparam logic [CW-1:0] c_CPU  = CW'(CPU_CH);

    logic [SW-1:0] r_slot;
    logic [AW-1:0] r_ra;
    logic          r_ra_valid;
    logic          r_ra_we;
    logic [CW-1:0] r_ra_ch;
    logic          r_cpu_ack;

    logic [AW-1:0] w_addr [NCH];
    logic [3:0]    w_own;
    logic [CW-1:0] w_ch;
    logic          w_static_idle;
    logic          w_is_cpu;
    logic          w_go;
    logic          w_cpu_grant;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_addr
        assign w_addr[gi] = ch_addr[gi*AW +: AW];
    end

    assign w_own         = SLOT_MAP[{r_slot, 2'b00} +: 4];
    assign w_static_idle = (w_own == CH_IDLE) || (w_own >= c_NCH4);
    assign w_ch          = w_own[CW-1:0];
    assign w_is_cpu      = (w_ch == c_CPU);
    // A slot carries an access only if its owner exists, is enabled and,
    // for the CPU, is currently requesting.
    assign w_go          = !w_static_idle && ch_en[w_ch] && (!w_is_cpu || cpu_req);
    assign w_cpu_grant   = w_go && w_is_cpu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot     <= '0;
            r_ra       <= '0;
            r_ra_valid <= 1'b0;
            r_ra_we    <= 1'b0;
            r_ra_ch    <= '0;
            r_cpu_ack  <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            if (ce) begin
                r_slot     <= sync ? '0 : r_slot + 1'b1;
                r_ra_valid <= w_go;
                r_ra_we    <= w_cpu_grant && cpu_we;
                r_cpu_ack  <= w_cpu_grant;
                if (!w_static_idle) begin
                    r_ra_ch <= w_ch;
                end
                // Address bus only moves on real accesses to avoid idle toggling.
                if (w_go) begin
                    r_ra <= w_addr[w_ch];
                end
            end
        end
    end

    vram_tag_pipe #(
        .NCH    (NCH),
        .CW     (CW),
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (reset),
        .i_ce     (ce),
        .i_valid  (w_go && !(w_cpu_grant && cpu_we)),
        .i_ch     (w_ch),
        .o_rd_stb (rd_stb)
    );

    assign slot     = r_slot;
    assign ra       = r_ra;
    assign ra_valid = r_ra_valid;
    assign ra_we    = r_ra_we;
    assign ra_ch    = r_ra_ch;
    assign cpu_ack  = r_cpu_ack;

endmodule
`default_nettype wire

// File: tb/tb_vram_addr_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_vram_addr_seq
// Brief   : Directed self-checking bench for vram_addr_seq (default and 8ch/16slot).
// Rev     : 1.0  initial release
// ============================================================================
module tb_vram_addr_seq;

    localparam int AW  = 13;
    localparam int NCH = 4;
    localparam int AWB  = 16;
    localparam int NCHB = 8;
    localparam logic [63:0] MAP_B = 64'h01F7_0605_F403_0201;

    // Owners per slot, read LSB nibble first from the slot maps.
    int own_a [8]  = '{1, 0, 1, 0, 2, 0, 3, 0};
    int own_b [16] = '{1, 0, 2, 0, 3, 0, 4, 15, 5, 0, 6, 0, 7, 15, 1, 0};
    logic [AW-1:0]  addr_a [4] = '{13'h1ABC, 13'h0111, 13'h0222, 13'h0333};
    logic [AWB-1:0] addr_b [8] = '{16'hC0DE, 16'h10A5, 16'h20A5, 16'h30A5,
                                   16'h40A5, 16'h50A5, 16'h60A5, 16'h70A5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, ce, sync, cpu_req, cpu_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH-1:0]    ch_en;
    logic              cpu_ack, ra_valid, ra_we;
    logic [AW-1:0]     ra;
    logic [1:0]        ra_ch;
    logic [NCH-1:0]    rd_stb;
    logic [2:0]        slot;

    logic                reset_b, cpu_req_b, cpu_we_b;
    logic [NCHB*AWB-1:0] ch_addr_b;
    logic [NCHB-1:0]     ch_en_b;
    logic                cpu_ack_b, ra_valid_b, ra_we_b;
    logic [AWB-1:0]      ra_b;
    logic [2:0]          ra_ch_b;
    logic [NCHB-1:0]     rd_stb_b;
    logic [3:0]          slot_b;

    vram_addr_seq #(.AW(AW), .NCH(NCH), .SLOTS(8), .CPU_CH(0), .RD_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .ce(ce), .sync(sync), .ch_addr(ch_addr), .ch_en(ch_en),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ack(cpu_ack), .ra(ra), .ra_valid(ra_valid),
        .ra_we(ra_we), .ra_ch(ra_ch), .rd_stb(rd_stb), .slot(slot)
    );

    vram_addr_seq #(.AW(AWB), .NCH(NCHB), .SLOTS(16), .SLOT_MAP(MAP_B), .CPU_CH(0),
                    .RD_LAT(4)) u_dut_b (
        .clk(clk), .reset(reset_b), .ce(ce), .sync(sync), .ch_addr(ch_addr_b),
        .ch_en(ch_en_b), .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_ack(cpu_ack_b),
        .ra(ra_b), .ra_valid(ra_valid_b), .ra_we(ra_we_b), .ra_ch(ra_ch_b),
        .rd_stb(rd_stb_b), .slot(slot_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int ch);
        return 32'd1 << ch;
    endfunction

    task automatic run_to_slot(input int s);
        for (int i = 0; i < 40 && int'(slot) != s; i++) @(negedge clk);
        check_eq("align slot", 32'(slot), 32'(s));
    endtask

    int            o, po, n_ack, n_rd;
    logic [AW-1:0] last_ra, prev_ra;
    logic [2:0]    prev_slot;
    logic [AWB-1:0] last_ra_b;
    int            last_ch_b;
    bit            isrd_b [32];
    int            ch_b   [32];
    logic [31:0]   exp_stb;

    initial begin
        reset = 1'b1; ce = 1'b1; sync = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; ch_en = '1;
        ch_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
        reset_b = 1'b1; cpu_req_b = 1'b0; cpu_we_b = 1'b0; ch_en_b = '1;
        for (int i = 0; i < NCHB; i++) ch_addr_b[i*AWB +: AWB] = addr_b[i];

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst slot", 32'(slot), 0);
        check_eq("rst ra", 32'(ra), 0);
        check_eq("rst ra_valid", 32'(ra_valid), 0);
        check_eq("rst ra_we", 32'(ra_we), 0);
        check_eq("rst ra_ch", 32'(ra_ch), 0);
        check_eq("rst cpu_ack", 32'(cpu_ack), 0);
        check_eq("rst rd_stb", 32'(rd_stb), 0);

        // Free-running round, CPU idle
        reset = 1'b0;
        last_ra = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            o  = own_a[k % 8];
            po = own_a[(k + 6) % 8];
            check_eq("p1 slot", 32'(slot), 32'((k + 1) % 8));
            check_eq("p1 ra_ch", 32'(ra_ch), 32'(o));
            check_eq("p1 ra_valid", 32'(ra_valid), 32'(o != 0));
            if (o != 0) last_ra = addr_a[o];
            check_eq("p1 ra", 32'(ra), 32'(last_ra));
            check_eq("p1 ra_we", 32'(ra_we), 0);
            check_eq("p1 cpu_ack", 32'(cpu_ack), 0);
            check_eq("p1 rd_stb", 32'(rd_stb), (k >= 2 && po != 0) ? oh(po) : 0);
        end

        // CPU write then CPU read
        run_to_slot(0);
        cpu_req = 1'b1; cpu_we = 1'b1;
        @(negedge clk);
        check_eq("p2 early ack", 32'(cpu_ack), 0);
        @(negedge clk);
        check_eq("p2 wr slot", 32'(slot), 2);
        check_eq("p2 wr ra", 32'(ra), 32'h1ABC);
        check_eq("p2 wr ra_we", 32'(ra_we), 1);
        check_eq("p2 wr ra_valid", 32'(ra_valid), 1);
        check_eq("p2 wr ra_ch", 32'(ra_ch), 0);
        check_eq("p2 wr ack", 32'(cpu_ack), 1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk);
        check_eq("p2 ack 1clk", 32'(cpu_ack), 0);
        check_eq("p2 ra_we drop", 32'(ra_we), 0);
        check_eq("p2 stb ch1", 32'(rd_stb), 32'h2);
        cpu_req = 1'b1;
        @(negedge clk);
        check_eq("p2 rd ack", 32'(cpu_ack), 1);
        check_eq("p2 rd ra_we", 32'(ra_we), 0);
        check_eq("p2 no stb for wr", 32'(rd_stb), 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("p2 stb not early", 32'(rd_stb), 32'h2);
        @(negedge clk);
        check_eq("p2 stb cpu rd", 32'(rd_stb), 32'h1);

        // sync mid-round with reads in flight
        run_to_slot(4);
        cpu_req = 1'b1;
        @(negedge clk);
        check_eq("p3 ra_ch slot4", 32'(ra_ch), 2);
        sync = 1'b1;
        @(negedge clk);
        check_eq("p3 sync slot", 32'(slot), 0);
        check_eq("p3 sync ack", 32'(cpu_ack), 1);
        sync = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check_eq("p3 stb ch2", 32'(rd_stb), 32'h4);
        @(negedge clk);
        check_eq("p3 stb cpu", 32'(rd_stb), 32'h1);

        // ce one clk in four; sync without ce has no effect
        cpu_req = 1'b1;
        prev_slot = slot; prev_ra = ra; n_ack = 0; n_rd = 0;
        for (int i = 0; i < 40; i++) begin
            ce = (i % 4 == 0);
            sync = (i == 5);
            @(negedge clk);
            if (ce) begin
                check_eq("p4 slot step", 32'(slot), 32'((int'(prev_slot) + 1) % 8));
            end else begin
                check_eq("p4 slot hold", 32'(slot), 32'(prev_slot));
                check_eq("p4 ra hold", 32'(ra), 32'(prev_ra));
                check_eq("p4 ack low", 32'(cpu_ack), 0);
                check_eq("p4 stb low", 32'(rd_stb), 0);
            end
            if (cpu_ack) begin
                n_ack++;
                cpu_req = 1'b0;
            end else begin
                cpu_req = 1'b1;
            end
            if (rd_stb[0]) n_rd++;
            prev_slot = slot; prev_ra = ra;
        end
        ce = 1'b1; sync = 1'b0; cpu_req = 1'b0;
        check_eq("p4 ack count", 32'(n_ack), 5);
        check_eq("p4 cpu stb count", 32'(n_rd), 4);

        // Disabled channel leaves its slot idle
        run_to_slot(2);
        ch_en = 4'b1011;
        run_to_slot(4);
        @(negedge clk);
        check_eq("p5 idle valid", 32'(ra_valid), 0);
        check_eq("p5 idle ra hold", 32'(ra), 32'h0111);
        check_eq("p5 idle slot", 32'(slot), 5);
        @(negedge clk);
        @(negedge clk);
        check_eq("p5 no stb ch2", 32'(rd_stb), 0);
        ch_en = '1;

        // Reset with a CPU request pending
        run_to_slot(0);
        cpu_req = 1'b1; cpu_we = 1'b0;
        @(negedge clk);
        check_eq("p6 pre slot", 32'(slot), 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("p6 rst ack", 32'(cpu_ack), 0);
        check_eq("p6 rst slot", 32'(slot), 0);
        check_eq("p6 rst valid", 32'(ra_valid), 0);
        check_eq("p6 rst ra", 32'(ra), 0);
        check_eq("p6 rst stb", 32'(rd_stb), 0);
        @(negedge clk);
        check_eq("p6 rst stb2", 32'(rd_stb), 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("p6 post ack0", 32'(cpu_ack), 0);
        @(negedge clk);
        check_eq("p6 regrant ack", 32'(cpu_ack), 1);
        check_eq("p6 regrant ra", 32'(ra), 32'h1ABC);
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("p6 stb ch1", 32'(rd_stb), 32'h2);
        @(negedge clk);
        check_eq("p6 stb cpu", 32'(rd_stb), 32'h1);

        // Wide configuration: 8 channels, 16 slots, idle map entries, RD_LAT=4
        cpu_req_b = 1'b1;
        @(negedge clk);
        check_eq("B rst slot", 32'(slot_b), 0);
        check_eq("B rst valid", 32'(ra_valid_b), 0);
        check_eq("B rst stb", 32'(rd_stb_b), 0);
        reset_b = 1'b0;
        last_ra_b = '0; last_ch_b = 0;
        for (int k = 0; k < 32; k++) begin
            cpu_we_b = (k >= 16);
            @(negedge clk);
            o = own_b[k % 16];
            isrd_b[k] = (o != 15) && !(o == 0 && cpu_we_b);
            ch_b[k]   = o;
            if (o != 15) begin
                last_ch_b = o;
                last_ra_b = addr_b[o];
            end
            check_eq("B slot", 32'(slot_b), 32'((k + 1) % 16));
            check_eq("B ra_ch", 32'(ra_ch_b), 32'(last_ch_b));
            check_eq("B ra_valid", 32'(ra_valid_b), 32'(o != 15));
            check_eq("B ra_we", 32'(ra_we_b), 32'(o == 0 && k >= 16));
            check_eq("B cpu_ack", 32'(cpu_ack_b), 32'(o == 0));
            check_eq("B ra", 32'(ra_b), 32'(last_ra_b));
            exp_stb = (k >= 4 && isrd_b[k-4]) ? oh(ch_b[k-4]) : 0;
            check_eq("B rd_stb", 32'(rd_stb_b), exp_stb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
